// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared types and helpers for the bitmask encoder.
//               enc_state_t - drain FSM state encoding
//               ENC_N_DEF   - default mask width
//               clog2       - ceiling log2 used to size the code output
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  localparam int ENC_N_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // Ceiling log2 of v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc
// Description : Combinational priority encoder with selectable direction.
// Ports       : vec       in  N  candidate bits
//               msb_first in  1  1: highest set bit wins, 0: lowest wins
//               idx       out W  index of the winning bit (0 when vec==0)
//               onehot    out 1  vec has exactly one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc
  import enc_pkg::*;
#(
  parameter int N = ENC_N_DEF,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic         msb_first,
  output logic [W-1:0] idx,
  output logic         onehot
);

  always_comb begin
    idx = '0;
    if (msb_first) begin
      // Ascending scan: the last match is the highest set bit.
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      // Descending scan: the last match is the lowest set bit.
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign onehot = ($countones(vec) == 1);

endmodule : prio_enc
`default_nettype wire

// File: rtl/bitmask_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bitmask_encoder
// Description : Accepts an N-bit request mask and streams out the binary
//               index of every set bit, one per valid/ready transfer, in
//               priority order. A mask is fully drained before the next one
//               is accepted; an all-zero mask is accepted and dropped.
// Config      : ENC_MSB_FIRST_EN - when defined, highest set bit is emitted
//               first; otherwise lowest set bit first.
// Ports       : clk       in   1  rising-edge clock
//               rst       in   1  synchronous active-high reset
//               in_valid  in   1  in_mask valid
//               in_ready  out  1  block can accept a mask
//               in_mask   in   N  request bits (bit i requests code i)
//               out_valid out  1  out_code/out_last valid
//               out_ready in   1  consumer accepts current code
//               out_code  out  W  index of selected pending bit
//               out_last  out  1  current code is final for this mask
//               busy      out  1  a mask is being drained
// Revision    : 1.0 - initial release
// ============================================================================
module bitmask_encoder
  import enc_pkg::*;
#(
  parameter int N = ENC_N_DEF,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         busy
);

`ifdef ENC_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  enc_state_t   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] w_sel_bit;

  // Code and last flag come only from the pend register, never from in_mask.
  prio_enc #(
    .N (N)
  ) u_prio_enc (
    .vec       (pend_q),
    .msb_first (MSB_FIRST),
    .idx       (out_code),
    .onehot    (out_last)
  );

  assign w_sel_bit = {{(N-1){1'b0}}, 1'b1} << out_code;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid && (in_mask != '0)) begin
          pend_d  = in_mask;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d = pend_q & ~w_sel_bit;
          if (out_last) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);

endmodule : bitmask_encoder
`default_nettype wire
